signal_freq_meter: RTL and testbench

- Measures an asynchronous digital input (external pin or board-generated slow clock) in the 50 MHz domain.
- Counts rising edges and high-time cycles over a fixed gate window of GATE_CYCLES clocks (1 s by default).
- At the end of each window, latches both counts and pulses a valid strobe.
- Acts as the measuring/receiving counterpart to the board's divided-clock generators. Its results feed display counters and self-check logic.

---
 rtl/signal_freq_meter.sv | 222 ++++++++++++++++++++++
 tb/tb_signal_freq_meter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/signal_freq_meter.sv
// -----------------------------------------------------------------------------
// signal_freq_meter
//
// Measures an asynchronous digital input in the clk_50MHz domain. Over a fixed
// gate window of GATE_CYCLES clocks it counts rising edges of the synchronized
// input and the number of cycles the synchronized input was high. At the end of
// each window both counts are latched into the outputs and freq_valid pulses
// for one cycle.
//
// Ports:
//   clk_50MHz    in   1       system clock, 50 MHz
//   reset_button in   1       asynchronous, active-high reset
//   sig_in       in   1       asynchronous signal under measurement
//   freq_count   out  CNT_W   rising edges in the last completed gate (saturating)
//   high_cycles  out  HIGH_W  armed cycles in the last gate with the input high
//   freq_valid   out  1       one-cycle strobe when the results update
//   overflow     out  1       edge counter saturated during the last gate
//   sig_present  out  1       last completed gate saw at least one edge
//
// Parameters:
//   GATE_CYCLES  gate window length in clocks (8 .. 2**HIGH_W)
//   CNT_W        width of the edge counter and freq_count
//   HIGH_W       width of the gate counter and high_cycles
//   SYNC_STAGES  synchronizer depth (>= 2)
// -----------------------------------------------------------------------------
module signal_freq_meter #(
    parameter int GATE_CYCLES = 50000000,
    parameter int CNT_W       = 27,
    parameter int HIGH_W      = 26,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_50MHz,
    input  logic              reset_button,
    input  logic              sig_in,
    output logic [CNT_W-1:0]  freq_count,
    output logic [HIGH_W-1:0] high_cycles,
    output logic              freq_valid,
    output logic              overflow,
    output logic              sig_present
);

    // Warm-up runs 0..SYNC_STAGES+1; the meter arms on the last value so the
    // synchronizer and prev sample hold real post-reset data before counting.
    localparam int                WARM_MAX  = SYNC_STAGES + 1;
    localparam int                WARM_W    = $clog2(WARM_MAX + 1);
    localparam logic [WARM_W-1:0] WARM_PRE  = WARM_W'(WARM_MAX - 1);
    localparam logic [HIGH_W-1:0] GATE_LAST = HIGH_W'(GATE_CYCLES - 1);

    typedef enum logic [0:0] {
        WARM_UNARMED = 1'b0,
        WARM_ARMED   = 1'b1
    } warm_state_t;

    // Saturating increment of the edge counter; bit CNT_W flags saturation.
    function automatic logic [CNT_W:0] edge_sat_add(
        input logic [CNT_W-1:0] acc,
        input logic             inc
    );
        logic [CNT_W:0] res;
        if (inc && (acc == {CNT_W{1'b1}})) begin
            res = {1'b1, acc};
        end else begin
            res = {1'b0, acc + CNT_W'(inc)};
        end
        return res;
    endfunction

    // Saturating increment of the high-time counter. It can only saturate
    // when GATE_CYCLES == 2**HIGH_W and the input is high for a whole gate;
    // holding at all-ones then is preferable to wrapping to a tiny value.
    function automatic logic [HIGH_W-1:0] high_sat_add(
        input logic [HIGH_W-1:0] acc,
        input logic              inc
    );
        logic [HIGH_W-1:0] res;
        if (inc && (acc == {HIGH_W{1'b1}})) begin
            res = acc;
        end else begin
            res = acc + HIGH_W'(inc);
        end
        return res;
    endfunction

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    warm_state_t            warm_state_r;
    warm_state_t            warm_state_next_s;
    logic [WARM_W-1:0]      warm_cnt_r;
    logic [WARM_W-1:0]      warm_cnt_next_s;
    logic [HIGH_W-1:0]      gate_cnt_r;
    logic [CNT_W-1:0]       edge_cnt_r;
    logic [HIGH_W-1:0]      high_cnt_r;
    logic                   ovf_acc_r;

    logic                   sync_s;
    logic                   armed_s;
    logic                   rise_s;
    logic                   high_s;
    logic                   terminal_s;
    logic [CNT_W:0]         edge_add_s;
    logic [CNT_W-1:0]       edge_sum_s;
    logic                   edge_sat_s;
    logic [HIGH_W-1:0]      high_sum_s;

    // Input synchronizer chain and one-cycle-delayed sample for edge detect.
    always_ff @(posedge clk_50MHz or posedge reset_button) begin
        if (reset_button) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], sig_in};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Warm-up state register.
    always_ff @(posedge clk_50MHz or posedge reset_button) begin
        if (reset_button) begin
            warm_state_r <= WARM_UNARMED;
            warm_cnt_r   <= {WARM_W{1'b0}};
        end else begin
            warm_state_r <= warm_state_next_s;
            warm_cnt_r   <= warm_cnt_next_s;
        end
    end

    // Warm-up next state: count up while unarmed, then stay armed until reset.
    always_comb begin
        warm_state_next_s = warm_state_r;
        warm_cnt_next_s   = warm_cnt_r;
        case (warm_state_r)
            WARM_UNARMED: begin
                warm_cnt_next_s = warm_cnt_r + WARM_W'(1'b1);
                if (warm_cnt_r == WARM_PRE) begin
                    warm_state_next_s = WARM_ARMED;
                end else begin
                    warm_state_next_s = WARM_UNARMED;
                end
            end
            WARM_ARMED: begin
                warm_cnt_next_s   = warm_cnt_r;
                warm_state_next_s = WARM_ARMED;
            end
            default: begin
                warm_cnt_next_s   = {WARM_W{1'b0}};
                warm_state_next_s = WARM_UNARMED;
            end
        endcase
    end

    // Warm-up output: armed gates all counting.
    always_comb begin
        armed_s = 1'b0;
        case (warm_state_r)
            WARM_ARMED:   armed_s = 1'b1;
            WARM_UNARMED: armed_s = 1'b0;
            default:      armed_s = 1'b0;
        endcase
    end

    // Per-cycle measurement terms and the closing values for the gate.
    always_comb begin
        rise_s     = armed_s & sync_s & ~prev_r;
        high_s     = armed_s & sync_s;
        terminal_s = (gate_cnt_r == GATE_LAST);
        edge_add_s = edge_sat_add(edge_cnt_r, rise_s);
        edge_sum_s = edge_add_s[CNT_W-1:0];
        edge_sat_s = edge_add_s[CNT_W];
        high_sum_s = high_sat_add(high_cnt_r, high_s);
    end

    // Gate timebase: free-running 0..GATE_CYCLES-1 from reset release.
    always_ff @(posedge clk_50MHz or posedge reset_button) begin
        if (reset_button) begin
            gate_cnt_r <= {HIGH_W{1'b0}};
        end else if (terminal_s) begin
            gate_cnt_r <= {HIGH_W{1'b0}};
        end else begin
            gate_cnt_r <= gate_cnt_r + HIGH_W'(1'b1);
        end
    end

    // In-gate accumulators; cleared on the terminal cycle, whose own edge and
    // high sample are folded into the closing result instead.
    always_ff @(posedge clk_50MHz or posedge reset_button) begin
        if (reset_button) begin
            edge_cnt_r <= {CNT_W{1'b0}};
            high_cnt_r <= {HIGH_W{1'b0}};
            ovf_acc_r  <= 1'b0;
        end else if (terminal_s) begin
            edge_cnt_r <= {CNT_W{1'b0}};
            high_cnt_r <= {HIGH_W{1'b0}};
            ovf_acc_r  <= 1'b0;
        end else begin
            edge_cnt_r <= edge_sum_s;
            high_cnt_r <= high_sum_s;
            ovf_acc_r  <= ovf_acc_r | edge_sat_s;
        end
    end

    // Result registers: load at gate end, hold otherwise; strobe for one cycle.
    always_ff @(posedge clk_50MHz or posedge reset_button) begin
        if (reset_button) begin
            freq_count  <= {CNT_W{1'b0}};
            high_cycles <= {HIGH_W{1'b0}};
            freq_valid  <= 1'b0;
            overflow    <= 1'b0;
            sig_present <= 1'b0;
        end else if (terminal_s) begin
            freq_count  <= edge_sum_s;
            high_cycles <= high_sum_s;
            freq_valid  <= 1'b1;
            overflow    <= ovf_acc_r | edge_sat_s;
            sig_present <= (edge_sum_s != {CNT_W{1'b0}});
        end else begin
            freq_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_signal_freq_meter.sv
// -----------------------------------------------------------------------------
// tb_signal_freq_meter
//
// Directed bench for signal_freq_meter with a 100-cycle gate. A main instance
// (CNT_W=8) and a saturation instance (CNT_W=4) share clock, reset and input.
// Expected gate results are queued as each gate's stimulus starts and are
// popped when the corresponding freq_valid strobe appears. Cycle numbers k are
// counted from the first reset release and the input waveform is a function
// of k, so the expected counts follow directly from the waveform.
// -----------------------------------------------------------------------------
module tb_signal_freq_meter;

    logic       clk_50MHz = 1'b0;
    logic       reset_button;
    logic       sig_in;

    logic [7:0] freq_count;
    logic [7:0] high_cycles;
    logic       freq_valid;
    logic       overflow;
    logic       sig_present;

    logic [3:0] s_freq_count;
    logic [7:0] s_high_cycles;
    logic       s_freq_valid;
    logic       s_overflow;
    logic       s_sig_present;

    typedef struct {
        int cyc;
        bit check;
        int fc;
        int hc;
        int ovf;
        int pres;
    } exp_t;

    exp_t q_main[$];
    exp_t q_small[$];

    int total = 0;
    int bad   = 0;
    int kk    = 0;
    int base  = 0;

    signal_freq_meter #(
        .GATE_CYCLES(100), .CNT_W(8), .HIGH_W(8), .SYNC_STAGES(2)
    ) dut (
        .clk_50MHz(clk_50MHz), .reset_button(reset_button), .sig_in(sig_in),
        .freq_count(freq_count), .high_cycles(high_cycles),
        .freq_valid(freq_valid), .overflow(overflow), .sig_present(sig_present)
    );

    signal_freq_meter #(
        .GATE_CYCLES(100), .CNT_W(4), .HIGH_W(8), .SYNC_STAGES(2)
    ) dut_sat (
        .clk_50MHz(clk_50MHz), .reset_button(reset_button), .sig_in(sig_in),
        .freq_count(s_freq_count), .high_cycles(s_high_cycles),
        .freq_valid(s_freq_valid), .overflow(s_overflow), .sig_present(s_sig_present)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    always @(posedge clk_50MHz) kk <= kk + 1;

    function automatic int kn();
        return kk - base;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic push_main(input int c, input bit ck, input int fc, input int hc,
                             input int ovf, input int pres);
        q_main.push_back('{cyc: c, check: ck, fc: fc, hc: hc, ovf: ovf, pres: pres});
    endtask

    task automatic push_small(input int c, input int fc, input int hc,
                              input int ovf, input int pres);
        q_small.push_back('{cyc: c, check: 1'b1, fc: fc, hc: hc, ovf: ovf, pres: pres});
    endtask

    // Drive sig_in until cycle until_k; per==0 means constant level hi.
    task automatic drive(input int until_k, input int per, input int hi);
        while (kn() < until_k) begin
            if (per == 0) sig_in = (hi != 0);
            else          sig_in = ((kn() % per) < hi);
            @(posedge clk_50MHz);
            #1;
        end
    endtask

    // Main scoreboard: every strobe must match the next queued gate.
    always @(negedge clk_50MHz) begin
        exp_t e;
        if (freq_valid === 1'b1) begin
            total++;
            assert (q_main.size() > 0) else begin
                bad++;
                $error("FAIL main_unexpected_valid observed=strobe at k=%0d expected=none", kn());
            end
            if (q_main.size() > 0) begin
                e = q_main.pop_front();
                chk("main_valid_cycle", kn(), e.cyc);
                if (e.check) begin
                    chk("main_freq_count",  32'(freq_count),  e.fc);
                    chk("main_high_cycles", 32'(high_cycles), e.hc);
                    chk("main_overflow",    32'(overflow),    e.ovf);
                    chk("main_sig_present", 32'(sig_present), e.pres);
                end
            end
        end
    end

    // Saturation scoreboard: only gates queued for that instance are checked.
    always @(negedge clk_50MHz) begin
        exp_t e;
        if ((s_freq_valid === 1'b1) && (q_small.size() > 0) && (q_small[0].cyc == kn())) begin
            e = q_small.pop_front();
            chk("sat_freq_count",  32'(s_freq_count),  e.fc);
            chk("sat_high_cycles", 32'(s_high_cycles), e.hc);
            chk("sat_overflow",    32'(s_overflow),    e.ovf);
            chk("sat_sig_present", 32'(s_sig_present), e.pres);
        end
    end

    initial begin
        // Reset with the input already high.
        reset_button = 1'b1;
        sig_in       = 1'b1;
        repeat (3) @(posedge clk_50MHz);
        #1;
        chk("rst_freq_count",  32'(freq_count),   32'd0);
        chk("rst_high_cycles", 32'(high_cycles),  32'd0);
        chk("rst_freq_valid",  32'(freq_valid),   32'd0);
        chk("rst_overflow",    32'(overflow),     32'd0);
        chk("rst_sig_present", 32'(sig_present),  32'd0);
        chk("rst_sat_count",   32'(s_freq_count), 32'd0);
        base         = kk;
        reset_button = 1'b0;

        // Test 1: line high through release -> no edge, 97 armed high cycles.
        push_main(100, 1'b1, 0, 97, 0, 0);
        drive(100, 0, 1);

        // Test 2: period 10, 50% duty; gate 1 is the transition gate.
        push_main(200, 1'b0, 0, 0, 0, 0);
        drive(200, 10, 5);
        push_main(300, 1'b1, 10, 50, 0, 1);
        drive(300, 10, 5);
        push_main(400, 1'b1, 10, 50, 0, 1);
        drive(400, 10, 5);

        // Test 3: synchronized rise lands on terminal cycle 499 only.
        push_main(500, 1'b1, 1, 1, 0, 1);
        drive(497, 0, 0);
        drive(500, 0, 1);
        push_main(600, 1'b1, 0, 100, 0, 0);
        drive(600, 0, 1);

        // Test 6: line held low (first gate still sees two trailing high samples).
        push_main(700, 1'b1, 0, 2, 0, 0);
        drive(700, 0, 0);
        push_main(800, 1'b1, 0, 0, 0, 0);
        drive(800, 0, 0);

        // Test 4: period 4 saturates the 4-bit counter, then period 20.
        push_main(900, 1'b1, 25, 50, 0, 1);
        push_small(900, 15, 50, 1, 1);
        drive(900, 4, 2);
        push_main(1000, 1'b1, 25, 50, 0, 1);
        push_small(1000, 15, 50, 1, 1);
        drive(1000, 4, 2);
        push_main(1100, 1'b1, 5, 50, 0, 1);
        push_small(1100, 5, 50, 0, 1);
        drive(1100, 20, 10);
        push_main(1200, 1'b1, 5, 50, 0, 1);
        push_small(1200, 5, 50, 0, 1);
        drive(1200, 20, 10);

        // Test 5: reset at gate cycle 60 for three clocks, period-10 input.
        drive(1260, 10, 5);
        sig_in       = ((kn() % 10) < 5);
        reset_button = 1'b1;
        @(negedge clk_50MHz);
        chk("midrst_freq_count",  32'(freq_count),  32'd0);
        chk("midrst_high_cycles", 32'(high_cycles), 32'd0);
        chk("midrst_freq_valid",  32'(freq_valid),  32'd0);
        chk("midrst_overflow",    32'(overflow),    32'd0);
        chk("midrst_sig_present", 32'(sig_present), 32'd0);
        @(posedge clk_50MHz);
        #1;
        drive(1263, 10, 5);
        reset_button = 1'b0;
        push_main(1363, 1'b1, 10, 47, 0, 1);
        drive(1363, 10, 5);
        push_main(1463, 1'b1, 10, 50, 0, 1);
        drive(1463, 10, 5);
        drive(1470, 10, 5);

        chk("main_queue_drained", q_main.size(),  32'd0);
        chk("sat_queue_drained",  q_small.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
